// File: rtl/uart_line_arbiter.sv
// Line-atomic arbiter sharing one UART print sink among NPORTS requesters.
// Define UART_ARB_TAG_EN to prefix every granted line with "<port>:".
module uart_line_arbiter #(
  parameter int NPORTS  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NPORTS*8-1:0]       req_data,
  input  logic [NPORTS-1:0]         req_valid,
  output logic [NPORTS-1:0]         req_ready,
  output logic [7:0]                uart_data,
  output logic                      uart_data_valid,
  output logic [$clog2(NPORTS)-1:0] owner,
  output logic                      busy
);

  localparam int OW = $clog2(NPORTS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
`ifdef UART_ARB_TAG_EN
    TAG_ID,
    TAG_SEP,
`endif
    PASS,
    BREAK
  } state_t;

  state_t          state;
  logic [OW-1:0]   last_port;
  logic [OW-1:0]   pick;
  logic [CW-1:0]   idle_cnt;
  logic [7:0]      sel_data;
  logic            xfer;
  logic            expire;

  assign sel_data = req_data[8*int'(owner) +: 8];
  assign xfer     = (state == PASS) && req_valid[owner];
  assign busy     = (state != IDLE);

  // Expire one cycle early so the break strobe lands TIMEOUT cycles after the last character.
  assign expire   = (TIMEOUT != 0) && ((int'(idle_cnt) + 1) >= (TIMEOUT - 1));

  // Round-robin pick starting at last_port+1; walking downwards lets the nearest port win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pick = last_port;
    for (int i = NPORTS; i >= 1; i--) begin
      if (req_valid[(int'(last_port) + i) % NPORTS])
        pick = OW'((int'(last_port) + i) % NPORTS);
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == PASS) req_ready[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      owner           <= '0;
      last_port       <= OW'(NPORTS - 1);
      idle_cnt        <= '0;
      uart_data       <= '0;
      uart_data_valid <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      uart_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner    <= pick;
            idle_cnt <= '0;
`ifdef UART_ARB_TAG_EN
            state    <= TAG_ID;
`else
            state    <= PASS;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        TAG_ID: begin
          uart_data       <= 8'h30 + 8'(owner);
          uart_data_valid <= 1'b1;
          state           <= TAG_SEP;
        end
        TAG_SEP: begin
          uart_data       <= 8'h3a;
          uart_data_valid <= 1'b1;
          idle_cnt        <= '0;
          state           <= PASS;
        end
`endif
        PASS: begin
          if (xfer) begin
            uart_data       <= sel_data;
            uart_data_valid <= 1'b1;
            idle_cnt        <= '0;
            if (sel_data == 8'h0a) begin
              last_port <= owner;
              state     <= IDLE;
            end
          end else if (expire) begin
            state <= BREAK;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        BREAK: begin
          uart_data       <= 8'h0a;
          uart_data_valid <= 1'b1;
          last_port       <= owner;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Directed bench for uart_line_arbiter; follows UART_ARB_TAG_EN for the expected line prefix.
module tb_uart_line_arbiter;

  localparam int NP = 4;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic            clk;
  logic            resetn;
  logic [8*NP-1:0] req_data;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_ready;
  logic [7:0]      uart_data;
  logic            uart_data_valid;
  logic [1:0]      owner;
  logic            busy;

  logic [8*NP-1:0] nt_data;
  logic [NP-1:0]   nt_valid;
  logic [NP-1:0]   nt_ready;
  logic [7:0]      nt_uart_data;
  logic            nt_uart_data_valid;
  logic [1:0]      nt_owner;
  logic            nt_busy;

  uart_line_arbiter #(.NPORTS(NP), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .uart_data(uart_data), .uart_data_valid(uart_data_valid),
    .owner(owner), .busy(busy)
  );

  uart_line_arbiter #(.NPORTS(NP), .TIMEOUT(0)) dut_nt (
    .clk(clk), .resetn(resetn), .req_data(nt_data), .req_valid(nt_valid),
    .req_ready(nt_ready), .uart_data(nt_uart_data), .uart_data_valid(nt_uart_data_valid),
    .owner(nt_owner), .busy(nt_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester model: each port streams the unsent tail of its string.
  string       src     [NP];
  int          src_pos [NP];
  int unsigned rise_cyc[NP];
  logic [NP-1:0] fire;

  initial begin
    req_valid = '0;
    req_data  = '0;
    fire      = '0;
    for (int p = 0; p < NP; p++) begin
      src[p] = "";
      src_pos[p] = 0;
      rise_cyc[p] = 0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (fire[p]) src_pos[p]++;
        if (src_pos[p] < src[p].len()) begin
          if (!req_valid[p]) rise_cyc[p] = cyc;
          req_valid[p] = 1'b1;
          req_data[8*p +: 8] = src[p][src_pos[p]];
        end else begin
          req_valid[p] = 1'b0;
        end
      end
      fire = req_valid & req_ready;
    end
  end

  typedef struct {
    logic [7:0]  d;
    int unsigned c;
    logic        b;
  } strobe_t;
  strobe_t mon[$];

  initial forever begin
    @(negedge clk);
    if (uart_data_valid === 1'b1) mon.push_back('{d: uart_data, c: cyc, b: busy});
  end

  function automatic string line(input int p, input string s);
    if (TAG) return {$sformatf("%0d:", p), s};
    return s;
  endfunction

  task automatic expect_stream(input string tag, input string exp, input int budget);
    int n = 0;
    while (mon.size() < exp.len() && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_count"}, mon.size(), exp.len());
    for (int i = 0; i < exp.len(); i++)
      if (i < mon.size()) check($sformatf("%s_ch%0d", tag, i), mon[i].d, exp[i]);
  endtask

  initial begin
    string       exp;
    string       rem;
    int          n;
    int          k;
    int unsigned x_cyc;
    int          nb_busy, nb_owner, nb_ready, nstrobe;
    logic [7:0]  last_d;

    nt_valid = '0;
    nt_data  = '0;
    resetn   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_uart_data", uart_data, 0);
    check("rst_uart_valid", uart_data_valid, 0);
    check("rst_ready", req_ready, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single port, back-to-back characters.
    exp = line(1, "hi\n");
    src[1] = {src[1], "hi\n"};
    expect_stream("t1", exp, 40);
    check("t1_latency", mon[0].c - rise_cyc[1], 2);
    check("t1_b2b", mon[mon.size()-1].c - mon[0].c, exp.len() - 1);
    check("t1_owner", owner, 1);
    check("t1_busy", busy, 0);
    mon.delete();

    // Contention from reset: port 0 first, then port 2, twice.
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    exp = line(0, "A\n");
    k = exp.len();
    exp = {exp, line(2, "B\n")};
    src[0] = {src[0], "A\n"};
    src[2] = {src[2], "B\n"};
    expect_stream("t2a", exp, 60);
    check("t2a_gap", mon[k].c - mon[k-1].c, 2);
    mon.delete();
    src[0] = {src[0], "A\n"};
    src[2] = {src[2], "B\n"};
    expect_stream("t2b", exp, 60);
    check("t2b_owner", owner, 2);
    mon.delete();

    // Stall mid-line: break after 8 idle cycles, then pending port 0.
    src[3] = {src[3], "x"};
    expect_stream("t3a", line(3, "x"), 40);
    x_cyc = mon[mon.size()-1].c;
    check("t3_busy_mid", busy, 1);
    mon.delete();
    src[0] = {src[0], "p\n"};
    expect_stream("t3b", {"\n", line(0, "p\n")}, 60);
    check("t3_break_delay", mon[0].c - x_cyc, 8);
    check("t3_break_busy", mon[0].b, 0);
    check("t3_regrant_gap", mon[1].c - mon[0].c, 2);
    check("t3_owner", owner, 0);
    mon.delete();

    // Reset in the middle of a line.
    src[1] = {src[1], "abcdef\n"};
    n = 0;
    while (mon.size() < (TAG ? 4 : 2) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("t4_started", mon.size() >= (TAG ? 4 : 2), 1);
    check("t4_busy_pre", busy, 1);
    #2 resetn = 1'b0;
    fire = '0;
    #1;
    check("t4_uart_data", uart_data, 0);
    check("t4_uart_valid", uart_data_valid, 0);
    check("t4_ready", req_ready, 0);
    check("t4_owner", owner, 0);
    check("t4_busy", busy, 0);
    rem = src[1].substr(src_pos[1], src[1].len() - 1);
    mon.delete();
    src[0] = {src[0], "z\n"};
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    expect_stream("t4_after", {line(0, "z\n"), line(1, rem)}, 80);
    mon.delete();

    // Disabled timeout: grant held through a long mid-line stall.
    nt_data[15:8] = "m";
    nt_valid = 4'b0010;
    n = 0;
    while (nt_ready[1] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_granted", nt_ready, 4'b0010);
    @(posedge clk);
    #1;
    nt_valid = 4'b0101;
    nt_data[7:0]   = "u";
    nt_data[23:16] = "v";
    nb_busy = 0; nb_owner = 0; nb_ready = 0; nstrobe = 0; last_d = '0;
    repeat (10000) begin
      @(negedge clk);
      if (nt_busy !== 1'b1) nb_busy++;
      if (nt_owner !== 2'd1) nb_owner++;
      if (nt_ready !== 4'b0010) nb_ready++;
      if (nt_uart_data_valid === 1'b1) begin
        nstrobe++;
        last_d = nt_uart_data;
      end
    end
    check("t5_busy_held", nb_busy, 0);
    check("t5_owner_held", nb_owner, 0);
    check("t5_others_blocked", nb_ready, 0);
    check("t5_strobes", nstrobe, 1);
    check("t5_char", last_d, 8'h6d);
    nt_data[15:8] = 8'h0a;
    nt_valid = 4'b0111;
    @(posedge clk);
    #1;
    nt_valid = 4'b0101;
    n = 0;
    while (nt_uart_data_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_eol", nt_uart_data, 8'h0a);
    repeat (3) @(negedge clk);
    check("t5_next_owner", nt_owner, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_line_arbiter.md
# uart_line_arbiter

Line-atomic arbiter that shares one simulation UART print sink among several requesters (CPU cores, boot ROM trace, peripheral debug taps). Each requester streams characters over a valid/ready handshake. The arbiter grants the sink for one whole line, from first character through 0x0a, so console lines never interleave. It drives the byte/valid pair consumed by the line-buffering print monitor and sits in the sim-support layer between requester debug ports and that monitor.

## Interface
- `NPORTS`, 4: number of requesters; legal range 2..10.
- `TIMEOUT`, 1024: idle cycles allowed mid-line before a forced line break; 0 disables the timeout.
- `clk`  in  1  sole clock; all logic on posedge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req_data`  in  NPORTS*8  character from port i on bits [8i+7:8i].
- `req_valid`  in  NPORTS  port i has a character.
- `req_ready`  out  NPORTS  port i character accepted this cycle when valid & ready.
- `uart_data`  out  8  character to the print sink.
- `uart_data_valid`  out  1  one-cycle strobe per character; the sink has no backpressure.
- `owner`  out  $clog2(NPORTS)  current or last granted port.
- `busy`  out  1  high while a line is granted (any state other than IDLE).

## Operation
- States: IDLE, TAG_ID, TAG_SEP, PASS, BREAK. TAG_* exist only with the macro enabled.
- **IDLE**
  - `req_ready` = 0.
  - If any `req_valid` is set, pick the first set port in round-robin order, starting at `last+1` mod NPORTS. Register it in `owner`.
  - Go to TAG_ID if tagging is enabled, otherwise PASS.
  - No character moves in the arbitration cycle.
- **PASS**
  - `req_ready[owner]` = 1, combinational from state; all other ready bits = 0.
  - On transfer, register `req_data[owner]` into `uart_data` and pulse `uart_data_valid` on the next cycle. At most one character per cycle.
  - If the transferred character is 0x0a: `last` <= `owner`, go to IDLE.
  - Idle counter: clears on each transfer and on entry to PASS; increments on PASS cycles with no transfer. When it reaches TIMEOUT-1 (TIMEOUT≠0), go to BREAK.
- **BREAK**
  - `req_ready` = 0.
  - Emit 0x0a (strobe next cycle), `last` <= `owner`, go to IDLE.
  - The interrupted port keeps its remaining characters and re-arbitrates normally.
- **Fairness:** round-robin is applied only at line boundaries. A port holding valid low mid-line keeps the grant until it sends 0x0a or times out.
- **Non-owners:** `req_valid` changes on non-owner ports while busy are ignored.
- **Widths:** idle counter is $clog2(TIMEOUT+1) bits and saturates. Tag character = 8'h30 + `owner`.

## Timing
- **Reset values:** `uart_data`=0, `uart_data_valid`=0, `req_ready`=0, `owner`=0, `busy`=0, state=IDLE, `last`=NPORTS-1 (port 0 wins the first arbitration).
- **Latency**
  - Request to first sink strobe (untagged): IDLE cycle, then PASS accept, then strobe = 2 cycles after `req_valid` rises.
  - Tagged: 4 cycles. The ID strobe appears in the cycle after TAG_ID, and the ':' strobe in the cycle after TAG_SEP.
- **Throughput:** back-to-back characters from the owner produce back-to-back strobes.
- **Line gap:** after 0x0a, the next line starts at least 1 IDLE cycle later.
- **Reset mid-line:** any state returns to IDLE asynchronously. No break character is emitted, and the sink's partial line is abandoned.
- **Simultaneous events:** a 0x0a transfer in the same cycle the counter would expire counts as a normal end of line; no BREAK.

## Configuration
- `UART_ARB_TAG_EN` defined:
  - At each new grant, emit the two-character prefix ASCII digit of `owner` followed by ':' before the first PASS cycle.
  - `req_ready` = 0 during TAG_ID and TAG_SEP.
  - The timeout counter does not run in TAG states.
- Undefined:
  - TAG states are not compiled; IDLE goes directly to PASS.
  - Output is the raw character stream.

## Test plan
- **Single port, untagged:** port 1 sends "hi\n" back-to-back → strobes 0x68, 0x69, 0x0a on consecutive cycles; first strobe 2 cycles after valid; `owner`=1.
- **Contention:** ports 0 and 2 both assert "A\n" and "B\n" from reset → port 0 line fully precedes port 2 line, with no interleaving. Repeat the requests → port 2 is still served after port 0 per rotation from `last`=2 (next order 0, then 2 alternates fairly).
- **Stall and timeout:** TIMEOUT=8; port 3 sends "x" then drops valid → 0x0a strobe 8 cycles after the 'x' transfer; `busy` falls; a pending port 0 is granted next.
- **Tagging:** with `UART_ARB_TAG_EN`, port 2 sends "ok\n" → strobes 0x32, 0x3a, 0x6f, 0x6b, 0x0a.
- **Reset mid-line:** assert `resetn` low during PASS after 2 characters → all outputs 0 immediately. After release, port 0 wins even if the previous owner is still requesting.
- **Disabled timeout:** TIMEOUT=0; owner idles 10000 cycles mid-line → no BREAK, grant is held, and other ports' `req_ready` stays 0.
